rand_walk_accum: RTL and testbench

//  Consumer of the lsfr random stream: every STEP_DIV enabled cycles, samples one signed 4-bit step from rand_in.

---
 rtl/rand_walk_pkg.sv | 17 +
 rtl/rand_step_timer.sv | 28 ++
 rtl/rand_walk_accum.sv | 113 +++++++++++
 tb/tb_rand_walk_accum.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rand_walk_pkg.sv
// rtl/rand_walk_pkg.sv - shared types, constants and step decoder for the random walk accumulator
package rand_walk_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        APPLY   = 2'd1,
        PRESENT = 2'd2
    } walk_state_e;

    localparam int STEP_W = 4;

    // 4'b1000 would give an asymmetric -8, so it is folded to 0 to keep the walk unbiased
    function automatic logic signed [STEP_W-1:0] decode_step(input logic [STEP_W-1:0] raw);
        return (raw == 4'b1000) ? '0 : $signed(raw);
    endfunction

endpackage

// File: rtl/rand_step_timer.sv
// rtl/rand_step_timer.sv - STEP_DIV divider with enable, sync clear and one-cycle terminal pulse
module rand_step_timer #(
    parameter int STEP_DIV = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic tick
);

    logic [15:0] div_cnt;
    logic        terminal;

    assign terminal = (div_cnt == 16'(STEP_DIV - 1));
    assign tick     = count_en && terminal && !clear;

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (count_en) begin
            div_cnt <= terminal ? '0 : div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/rand_walk_accum.sv
// rtl/rand_walk_accum.sv - bounded random walk fed by rand_in[3:0], presented over valid/ready
// Optional macro RAND_WALK_WRAP_EN: wrap out-of-range sums instead of saturating.
module rand_walk_accum
    import rand_walk_pkg::*;
#(
    parameter int                      WIDTH    = 32,
    parameter int                      STEP_DIV = 1000,
    parameter logic signed [WIDTH-1:0] POS_MIN  = -1000,
    parameter logic signed [WIDTH-1:0] POS_MAX  = 1000,
    parameter logic signed [WIDTH-1:0] INIT_POS = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [31:0]      rand_in,
    output logic [WIDTH-1:0] pos_out,
    output logic             pos_valid,
    input  logic             pos_ready,
    output logic [15:0]      step_count,
    output logic             sat_hit
);

    walk_state_e              state;
    logic                     step_tick;
    logic signed [STEP_W-1:0] step;
    logic signed [WIDTH+1:0]  sum;
    logic signed [WIDTH+1:0]  pos_min_x;
    logic signed [WIDTH+1:0]  pos_max_x;
    logic signed [WIDTH+1:0]  next_pos;
    logic                     out_of_range;
    logic                     unused_bits;

    rand_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .count_en (enable && (state == WAIT)),
        .clear    (clear),
        .tick     (step_tick)
    );

    assign step      = decode_step(rand_in[STEP_W-1:0]);
    assign pos_min_x = {{2{POS_MIN[WIDTH-1]}}, POS_MIN};
    assign pos_max_x = {{2{POS_MAX[WIDTH-1]}}, POS_MAX};
    // two guard bits: one for the add carry, one so the wrap range itself cannot overflow
    assign sum       = {{2{pos_out[WIDTH-1]}}, pos_out}
                     + {{(WIDTH + 2 - STEP_W){step[STEP_W-1]}}, step};

`ifdef RAND_WALK_WRAP_EN
    logic signed [WIDTH+1:0] range_x;
    assign range_x = pos_max_x - pos_min_x + (WIDTH + 2)'(1);
`endif

    always_comb begin
        next_pos     = sum;
        out_of_range = 1'b0;
        if (sum > pos_max_x) begin
            out_of_range = 1'b1;
`ifdef RAND_WALK_WRAP_EN
            next_pos     = sum - range_x;
`else
            next_pos     = pos_max_x;
`endif
        end else if (sum < pos_min_x) begin
            out_of_range = 1'b1;
`ifdef RAND_WALK_WRAP_EN
            next_pos     = sum + range_x;
`else
            next_pos     = pos_min_x;
`endif
        end
    end

    assign unused_bits = ^{rand_in[31:STEP_W], next_pos[WIDTH+1:WIDTH]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= WAIT;
            pos_out    <= INIT_POS;
            pos_valid  <= 1'b0;
            step_count <= '0;
            sat_hit    <= 1'b0;
        end else if (clear) begin
            state     <= WAIT;
            pos_out   <= INIT_POS;
            pos_valid <= 1'b0;
            sat_hit   <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (step_tick) state <= APPLY;
                end
                APPLY: begin
                    pos_out    <= next_pos[WIDTH-1:0];
                    step_count <= step_count + 16'd1;
                    pos_valid  <= 1'b1;
                    if (out_of_range) sat_hit <= 1'b1;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    if (pos_ready) begin
                        pos_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_walk_accum.sv
// tb/tb_rand_walk_accum.sv - randomized self-checking bench for rand_walk_accum
module tb_rand_walk_accum;

    localparam int WIDTH    = 32;
    localparam int STEP_DIV = 4;
    localparam int P_MIN    = -10;
    localparam int P_MAX    = 10;
    localparam int P_INIT   = 0;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             clear;
    logic [31:0]      rand_in;
    logic [WIDTH-1:0] pos_out;
    logic             pos_valid;
    logic             pos_ready;
    logic [15:0]      step_count;
    logic             sat_hit;

    int total;
    int bad;
    int m_pos;
    int m_cnt;
    int m_sat;

    rand_walk_accum #(
        .WIDTH    (WIDTH),
        .STEP_DIV (STEP_DIV),
        .POS_MIN  (P_MIN),
        .POS_MAX  (P_MAX),
        .INIT_POS (P_INIT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .rand_in    (rand_in),
        .pos_out    (pos_out),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .step_count (step_count),
        .sat_hit    (sat_hit)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pos_valid && n < 200);
        if (!pos_valid) check("valid_timeout", 0, 1);
    endtask

    function automatic void model_step(input logic [31:0] r);
        int s;
        int sum;
        s = int'(r[3:0]);
        if (s >= 8) s = s - 16;
        if (s == -8) s = 0;
        sum = m_pos + s;
        if (sum > P_MAX) begin
            m_sat = 1;
`ifdef RAND_WALK_WRAP_EN
            sum = sum - (P_MAX - P_MIN + 1);
`else
            sum = P_MAX;
`endif
        end else if (sum < P_MIN) begin
            m_sat = 1;
`ifdef RAND_WALK_WRAP_EN
            sum = sum + (P_MAX - P_MIN + 1);
`else
            sum = P_MIN;
`endif
        end
        m_pos = sum;
        m_cnt = (m_cnt + 1) % 65536;
    endfunction

    function automatic void model_clear();
        m_pos = P_INIT;
        m_sat = 0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_pos"}, longint'($signed(pos_out)), m_pos);
        check({tag, "_cnt"}, step_count, m_cnt);
        check({tag, "_sat"}, sat_hit, m_sat);
    endtask

    initial begin
        int          n;
        logic [31:0] p_snap;
        logic [15:0] c_snap;
        logic [31:0] r;
        int          stable;
        int          d;

        clock = 0; reset = 0; enable = 0; clear = 0; rand_in = '0; pos_ready = 0;
        total = 0; bad = 0; m_pos = P_INIT; m_cnt = 0; m_sat = 0;

        repeat (3) tick();
        check("rst_pos", longint'($signed(pos_out)), 0);
        check("rst_valid", pos_valid, 0);
        check("rst_cnt", step_count, 0);
        check("rst_sat", sat_hit, 0);

        // first step latency and steady-state period
        reset = 1; enable = 1; pos_ready = 1; rand_in = 32'h5;
        wait_valid(n);
        check("lat_first", n, STEP_DIV + 1);
        check("first_pos", longint'($signed(pos_out)), 5);
        model_step(rand_in); check_state("s1");
        wait_valid(n);
        check("period2", n, STEP_DIV + 2);
        model_step(rand_in); check_state("s2");
        wait_valid(n);
        check("period3", n, STEP_DIV + 2);
        model_step(rand_in); check_state("s3");

        // clear coinciding with handshake
        clear = 1; tick(); clear = 0;
        model_clear();
        check("clr_hs_valid", pos_valid, 0);
        check_state("clr_hs");

        // -8 pattern is a zero step
        rand_in = 32'hFFFF_FFF8;
        wait_valid(n);
        model_step(rand_in); check_state("neg8");

        // walk to 8 then overflow the upper bound
        rand_in = 32'h7; wait_valid(n); model_step(rand_in);
        rand_in = 32'h1; wait_valid(n); model_step(rand_in);
        check("at8", longint'($signed(pos_out)), 8);
        rand_in = 32'h7; wait_valid(n); model_step(rand_in);
`ifdef RAND_WALK_WRAP_EN
        check("bound_pos", longint'($signed(pos_out)), -6);
`else
        check("bound_pos", longint'($signed(pos_out)), 10);
`endif
        check("bound_sat", sat_hit, 1);
        check_state("bound");

        // backpressure stall
        pos_ready = 0;
        p_snap = pos_out; c_snap = step_count; stable = 1;
        repeat (20) begin
            tick();
            if (!(pos_valid && pos_out == p_snap && step_count == c_snap)) stable = 0;
        end
        check("stall_stable", stable, 1);
        pos_ready = 1; rand_in = 32'h2;
        tick();
        check("hs_valid", pos_valid, 0);
        wait_valid(n);
        check("lat_after_hs", n, STEP_DIV + 1);
        model_step(rand_in); check_state("after_stall");

        // clear in PRESENT, then enable freeze mid-WAIT
        clear = 1; tick(); clear = 0;
        model_clear();
        check("clr_pres_valid", pos_valid, 0);
        check_state("clr_pres");
        repeat (2) tick();
        enable = 0; stable = 1;
        repeat (10) begin
            tick();
            if (pos_valid) stable = 0;
        end
        check("freeze_no_valid", stable, 1);
        enable = 1; rand_in = 32'h3;
        wait_valid(n);
        check("lat_after_freeze", n, STEP_DIV - 1);
        model_step(rand_in); check_state("freeze");

        // clear landing on the APPLY cycle discards the step
        rand_in = 32'h6;
        tick();
        repeat (STEP_DIV) tick();
        clear = 1; tick(); clear = 0;
        model_clear();
        check("clr_apply_valid", pos_valid, 0);
        check_state("clr_apply");
        wait_valid(n);
        check("lat_after_clr", n, STEP_DIV + 1);
        model_step(rand_in); check_state("post_clr_apply");

        // randomized walk with random stalls and enable gaps
        for (int i = 0; i < 40; i++) begin
            pos_ready = 0;
            d = $urandom_range(0, 4);
            p_snap = pos_out; stable = 1;
            repeat (d) begin
                tick();
                if (!(pos_valid && pos_out == p_snap)) stable = 0;
            end
            check("rnd_stall", stable, 1);
            r = $urandom;
            if (i % 5 == 0) r[3:0] = 4'b1000;
            rand_in = r; pos_ready = 1;
            tick();
            enable = 0;
            repeat ($urandom_range(0, 3)) tick();
            enable = 1;
            wait_valid(n);
            check("rnd_lat", n, STEP_DIV + 1);
            model_step(r); check_state("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
